// File: rtl/rcc_div_ratio_ctrl.sv
// Sequences divider ratio changes: gate to 0, wait for stop, load new ratio, wait for run; ack 1 cycle
// after a same-ratio accept, >= GATE_CYC+2 after a full change; req_rdy only in IDLE, busy requests dropped.
module rcc_div_ratio_ctrl #(
  parameter int RATIO_WID = 8,
  parameter int RST_RATIO = 1,
  parameter int GATE_CYC  = 4,
  parameter int TMO_CYC   = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_vld,
  output logic                 req_rdy,
  input  logic [RATIO_WID-1:0] req_ratio,
  input  logic                 div_en_s,
  output logic [RATIO_WID-1:0] ratio,
  output logic [RATIO_WID-1:0] cur_ratio,
  output logic                 busy,
  output logic                 ack,
  output logic                 err
);

  localparam int TMR_WID = $clog2(TMO_CYC + 1);
  localparam logic [TMR_WID-1:0]   GATE_LAST = TMR_WID'(GATE_CYC - 1);
  localparam logic [TMR_WID-1:0]   TMO_LAST  = TMR_WID'(TMO_CYC - 1);
  localparam logic [RATIO_WID-1:0] RST_R     = RATIO_WID'(RST_RATIO);

  typedef enum logic [1:0] {IDLE, GATE, LOAD, ACK} state_t;

  state_t               state;
  logic [TMR_WID-1:0]   timer;
  logic [RATIO_WID-1:0] new_r;

  assign req_rdy = (state == IDLE);
  assign busy    = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      timer     <= '0;
      new_r     <= '0;
      ratio     <= RST_R;
      cur_ratio <= RST_R;
      ack       <= 1'b0;
      err       <= 1'b0;
    end else begin
      ack <= 1'b0;
      case (state)
        IDLE: begin
          if (req_vld) begin
            new_r <= req_ratio;
            err   <= 1'b0;
            timer <= '0;
            if (req_ratio == cur_ratio) begin
              state <= ACK;
              ack   <= 1'b1;
            end else if (cur_ratio == '0) begin
              // divider is already gated, so the new ratio can go straight out
              state <= LOAD;
              ratio <= req_ratio;
            end else begin
              state <= GATE;
              ratio <= '0;
            end
          end
        end
        GATE: begin
          if (timer >= GATE_LAST && !div_en_s) begin
            timer <= '0;
            if (new_r != '0) begin
              state <= LOAD;
              ratio <= new_r;
            end else begin
              state     <= ACK;
              ack       <= 1'b1;
              cur_ratio <= '0;
            end
          end else if (timer >= TMO_LAST) begin
            state     <= ACK;
            ack       <= 1'b1;
            err       <= 1'b1;
            cur_ratio <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        LOAD: begin
          // timer only advances below TMO_LAST, so it can never wrap
          if (div_en_s || timer >= TMO_LAST) begin
            state     <= ACK;
            ack       <= 1'b1;
            cur_ratio <= new_r;
            if (!div_en_s) err <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ACK: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/rcc_div_ratio_ctrl.md
Name: rcc_div_ratio_ctrl

Overview:
Sequences ratio changes for one dynamic clock divider in the RCC. A software or register request for a new divide ratio is never applied directly to a running divider. The block first gates the divider by driving ratio 0 and waiting for its status to drop, then loads the new ratio and waits for the divider to report running again. It sits in the clk domain between the RCC register block and the divider's ratio/div_en pins.

Parameters:
RATIO_WID, 8, width of the ratio bus.
RST_RATIO, 1, ratio driven out of reset; must fit in RATIO_WID.
GATE_CYC, 4, minimum cycles ratio is held at 0 before a load; must be >= 1 (covers the divider's 2-stage ratio sync plus margin).
TMO_CYC, 64, per-state timeout in cycles; must be > GATE_CYC.

Ports:
clk  in  1  block clock.
rst  in  1  synchronous reset, active-high.
req_vld  in  1  request valid.
req_rdy  out  1  request ready; high only in IDLE.
req_ratio  in  RATIO_WID  requested ratio; 0 means gate the divider off.
div_en_s  in  1  divider running status, already synchronised to clk by the caller.
ratio  out  RATIO_WID  registered ratio to the divider.
cur_ratio  out  RATIO_WID  last committed ratio.
busy  out  1  high whenever state != IDLE.
ack  out  1  one-cycle pulse marking sequence completion.
err  out  1  sticky timeout flag.

Behaviour:
- All outputs are registered except req_rdy and busy, which decode the state.
- Reset values, applied at any edge with rst=1 including mid-sequence: state=IDLE, ratio=RST_RATIO, cur_ratio=RST_RATIO, ack=0, err=0, timer=0.
- Accept occurs when req_vld & req_rdy are high at an edge.
  - req_ratio is captured into new_r.
  - err is cleared.
  - Requests while busy are ignored; no queueing.
- States and transitions:
  - IDLE, on accept:
    - new_r == cur_ratio -> ACK. No change to ratio.
    - cur_ratio == 0 and new_r != 0 -> LOAD. Gating is skipped.
    - Otherwise -> GATE.
  - GATE:
    - ratio=0 from the entry edge; timer counts from 0.
    - Exit once timer >= GATE_CYC-1 and div_en_s == 0. Ratio is therefore 0 for at least GATE_CYC cycles.
    - Exit to LOAD if new_r != 0.
    - Exit to ACK with cur_ratio=0 if new_r == 0.
    - If timer reaches TMO_CYC-1 with div_en_s still 1: go to ACK, set err=1, cur_ratio=0, ratio stays 0.
  - LOAD:
    - ratio=new_r from the entry edge; timer restarts at 0.
    - div_en_s == 1 -> ACK, cur_ratio=new_r.
    - Timer reaches TMO_CYC-1 -> ACK, err=1, cur_ratio=new_r, ratio stays new_r.
  - ACK: ack=1 for exactly one cycle, then IDLE. err, if set, stays valid until the next accept.
- Latency:
  - Same-ratio request: ack on the cycle after the accept edge.
  - Gate-to-zero: ack at least GATE_CYC+1 cycles after accept.
  - Full change: ack at least GATE_CYC+2 cycles after accept.
- The timer saturates and never wraps. Its width is clog2(TMO_CYC+1).
- ratio never changes from one nonzero value to another nonzero value in a single edge. Every nonzero-to-nonzero change passes through at least GATE_CYC cycles of 0.
- A div_en_s glitch in LOAD is accepted on its first high cycle. div_en_s is not re-checked after that.
- req_vld asserted on the same edge that ack pulses is not accepted: state is ACK, so req_rdy=0. It is accepted on the following edge if still held.

Test Plan:
- Reset then idle: ratio=1, cur_ratio=1, req_rdy=1, busy=0, ack=0, err=0.
- Same ratio: req 1 while cur_ratio=1 -> ack on next cycle, ratio never leaves 1, busy high for 1 cycle.
- Change 1->5 with default params, model dropping div_en_s 2 cycles after ratio=0 and raising it 3 cycles after ratio=5:
  - ratio=0 for exactly 4 cycles, then ratio=5.
  - ack once, cur_ratio=5, err=0.
- Gate off then on:
  - req 0 -> ratio=0, ack, cur_ratio=0.
  - Then req 3 -> GATE is skipped; ratio=3 the cycle after accept; ack after div_en_s rises.
- Timeouts:
  - Hold div_en_s=1 in GATE -> ack after 64 cycles, err=1, ratio=0.
  - Next accepted request clears err.
  - Hold div_en_s=0 in LOAD -> err=1, cur_ratio=new value.
- Disturbances:
  - req_vld pulses while busy are ignored and the captured ratio is unchanged.
  - rst=1 mid-LOAD -> next edge ratio=1, state IDLE, no ack.
